psp_rvfi_trace_buffer: RTL and testbench

//  Sits directly downstream of the core's RVFI retirement port and upstream of the RVFI monitor / trace sink.

---
 rtl/psp_rvfi_trace_buffer_if.sv | 49 ++++
 rtl/psp_rvfi_trace_buffer.sv | 164 ++++++++++++++++
 tb/tb_psp_rvfi_trace_buffer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/psp_rvfi_trace_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : psp_rvfi_trace_buffer_if
// Description : Retirement-in / trace-out handshake bundle for the RVFI
//               trace buffer.
//               in_*  : one retirement packet per in_valid cycle (no backpressure)
//               out_* : head packet, valid/ready drained by the trace sink
//               slave modport  -> the trace buffer
//               master modport -> the core / sink side (or a bench)
// Revision    : 1.0  initial release
// ============================================================================
interface psp_rvfi_trace_buffer_if #(
    parameter int XLEN = 32
) ();

    logic            in_valid;
    logic [XLEN-1:0] in_pc_rdata;
    logic [XLEN-1:0] in_pc_wdata;
    logic [31:0]     in_insn;
    logic            in_intr;
    logic [4:0]      in_rd_addr;
    logic [XLEN-1:0] in_rd_wdata;

    logic            out_valid;
    logic            out_ready;
    logic [63:0]     out_order;
    logic [XLEN-1:0] out_pc_rdata;
    logic [XLEN-1:0] out_pc_wdata;
    logic [31:0]     out_insn;
    logic            out_intr;
    logic [4:0]      out_rd_addr;
    logic [XLEN-1:0] out_rd_wdata;

    modport slave (
        input  in_valid, in_pc_rdata, in_pc_wdata, in_insn, in_intr,
               in_rd_addr, in_rd_wdata, out_ready,
        output out_valid, out_order, out_pc_rdata, out_pc_wdata, out_insn,
               out_intr, out_rd_addr, out_rd_wdata
    );

    modport master (
        output in_valid, in_pc_rdata, in_pc_wdata, in_insn, in_intr,
               in_rd_addr, in_rd_wdata, out_ready,
        input  out_valid, out_order, out_pc_rdata, out_pc_wdata, out_insn,
               out_intr, out_rd_addr, out_rd_wdata
    );

endinterface
`default_nettype wire

// File: rtl/psp_rvfi_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : psp_rvfi_trace_buffer
// Description : Buffers RVFI retirement packets between the core and the
//               trace sink. Every retirement gets a 64-bit order number
//               (stored or dropped, so gaps expose drops). Sticky status
//               flags report FIFO overflow and self-loop retirement.
// Ports       : clk            system clock
//               reset          synchronous, active-low
//               bus            retirement in / trace out handshake (slave)
//               count          occupied entries
//               overflow       sticky, a retirement was dropped
//               loop_detected  sticky, same pc_rdata retired twice in a row
//               loop_pc        pc of the first detected self-loop
// Revision    : 1.0  initial release
// ============================================================================
module psp_rvfi_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int XLEN  = 32
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    psp_rvfi_trace_buffer_if.slave        bus,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          overflow,
    output logic                          loop_detected,
    output logic [XLEN-1:0]               loop_pc
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    // order + pc_rdata + pc_wdata + insn + intr + rd_addr + rd_wdata
    localparam int c_EW = 64 + 3 * XLEN + 32 + 1 + 5;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    localparam logic [1:0] c_ST_RUN  = 2'd0;
    localparam logic [1:0] c_ST_LOOP = 2'd1;
    localparam logic [1:0] c_ST_OVF  = 2'd2;

    logic [c_EW-1:0] r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [63:0]     r_order;
    logic [XLEN-1:0] r_prev_pc;
    logic            r_prev_valid;
    logic            r_loop_detected;
    logic [XLEN-1:0] r_loop_pc;
    logic [1:0]      r_state;

    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_loop_hit;
    logic [c_EW-1:0] w_in_entry;
    logic [c_EW-1:0] w_head;

    // count alone decides full/empty; pointers wrap freely.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);
    assign w_pop   = !w_empty && bus.out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_push  = bus.in_valid && (!w_full || w_pop);
    assign w_drop  = bus.in_valid && w_full && !w_pop;

    assign w_loop_hit = bus.in_valid && r_prev_valid &&
                        (bus.in_pc_rdata == r_prev_pc) && !r_loop_detected;

    assign w_in_entry = {r_order, bus.in_pc_rdata, bus.in_pc_wdata, bus.in_insn,
                         bus.in_intr, bus.in_rd_addr, bus.in_rd_wdata};

    // Head fields read as zero whenever nothing is presented.
    assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

    assign bus.out_valid = !w_empty;
    assign {bus.out_order, bus.out_pc_rdata, bus.out_pc_wdata, bus.out_insn,
            bus.out_intr, bus.out_rd_addr, bus.out_rd_wdata} = w_head;

    assign count         = r_count;
    assign overflow      = (r_state == c_ST_OVF);
    assign loop_detected = r_loop_detected;
    assign loop_pc       = r_loop_pc;

    // Storage carries no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Order and previous-pc tracking advance on every retirement, even a
    // dropped one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_order         <= '0;
            r_prev_pc       <= '0;
            r_prev_valid    <= 1'b0;
            r_loop_detected <= 1'b0;
            r_loop_pc       <= '0;
        end else begin
            if (bus.in_valid) begin
                r_order      <= r_order + 64'd1;
                r_prev_pc    <= bus.in_pc_rdata;
                r_prev_valid <= 1'b1;
            end
            if (w_loop_hit) begin
                r_loop_detected <= 1'b1;
                r_loop_pc       <= bus.in_pc_rdata;
            end
        end
    end

    // Status FSM; overflow is a decode of the terminal OVF state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_ST_RUN;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_drop) begin
                        r_state <= c_ST_OVF;
                    end else if (w_loop_hit) begin
                        r_state <= c_ST_LOOP;
                    end
                end
                c_ST_LOOP: begin
                    if (w_drop) begin
                        r_state <= c_ST_OVF;
                    end
                end
                c_ST_OVF: begin
                    r_state <= c_ST_OVF;
                end
                default: begin
                    r_state <= c_ST_RUN;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psp_rvfi_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_psp_rvfi_trace_buffer
// Description : Scoreboard bench for psp_rvfi_trace_buffer. Retirements are
//               pushed to an expected-packet queue as they are driven; the
//               head presented by the DUT is compared against the queue front.
// Revision    : 1.0  initial release
// ============================================================================
module tb_psp_rvfi_trace_buffer;

    localparam int c_DEPTH = 16;
    localparam int c_XLEN  = 32;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] insn;
        logic        intr;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
    } pkt_t;

    logic       clk;
    logic       reset;
    logic [4:0] count;
    logic       overflow;
    logic       loop_detected;
    logic [31:0] loop_pc;

    psp_rvfi_trace_buffer_if #(.XLEN(c_XLEN)) bus ();

    psp_rvfi_trace_buffer #(
        .DEPTH (c_DEPTH),
        .XLEN  (c_XLEN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus.slave),
        .count         (count),
        .overflow      (overflow),
        .loop_detected (loop_detected),
        .loop_pc       (loop_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pkt_t        sb[$];
    int          n_checks;
    int          n_errors;
    logic [63:0] m_order;
    logic        m_prev_valid;
    logic [31:0] m_prev_pc;
    logic        m_ovf;
    logic        m_loop;
    logic [31:0] m_loop_pc;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic pkt_t dut_head();
        pkt_t p;
        p = {bus.out_order, bus.out_pc_rdata, bus.out_pc_wdata, bus.out_insn,
             bus.out_intr, bus.out_rd_addr, bus.out_rd_wdata};
        return p;
    endfunction

    // One clock: check outputs mid-cycle, advance the model, then cross the edge.
    task automatic cycle();
        pkt_t pin;
        logic pop;
        logic push;
        @(negedge clk);
        check("out_valid", bus.out_valid, sb.size() != 0);
        check("count", count, sb.size());
        check("overflow", overflow, m_ovf);
        check("loop_detected", loop_detected, m_loop);
        check("loop_pc", loop_pc, m_loop_pc);
        if (sb.size() != 0) check("head", dut_head(), sb[0]);
        else                check("head_zero", dut_head(), '0);
        if (!reset) begin
            sb.delete();
            m_order = '0; m_prev_valid = 1'b0; m_prev_pc = '0;
            m_ovf = 1'b0; m_loop = 1'b0; m_loop_pc = '0;
        end else begin
            pop  = (sb.size() != 0) && bus.out_ready;
            push = bus.in_valid && ((sb.size() < c_DEPTH) || pop);
            pin  = '0;
            if (bus.in_valid) begin
                pin.order    = m_order;
                pin.pc_rdata = bus.in_pc_rdata;
                pin.pc_wdata = bus.in_pc_wdata;
                pin.insn     = bus.in_insn;
                pin.intr     = bus.in_intr;
                pin.rd_addr  = bus.in_rd_addr;
                pin.rd_wdata = bus.in_rd_wdata;
                if (!push) m_ovf = 1'b1;
                if (m_prev_valid && bus.in_pc_rdata == m_prev_pc && !m_loop) begin
                    m_loop    = 1'b1;
                    m_loop_pc = bus.in_pc_rdata;
                end
                m_prev_valid = 1'b1;
                m_prev_pc    = bus.in_pc_rdata;
                m_order      = m_order + 64'd1;
            end
            if (pop)  void'(sb.pop_front());
            if (push) sb.push_back(pin);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] pc);
        bus.in_valid    = 1'b1;
        bus.in_pc_rdata = pc;
        bus.in_pc_wdata = pc + 32'd4;
        bus.in_insn     = $urandom;
        bus.in_intr     = 1'($urandom_range(0, 1));
        bus.in_rd_addr  = 5'($urandom_range(0, 31));
        bus.in_rd_wdata = (bus.in_rd_addr != 5'd0) ? $urandom : 32'd0;
        cycle();
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n, input logic rdy);
        bus.in_valid  = 1'b0;
        bus.out_ready = rdy;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
    endtask

    pkt_t held;

    initial begin
        n_checks = 0; n_errors = 0;
        m_order = '0; m_prev_valid = 1'b0; m_prev_pc = '0;
        m_ovf = 1'b0; m_loop = 1'b0; m_loop_pc = '0;
        reset = 1'b0;
        bus.in_valid = 1'b0; bus.in_pc_rdata = '0; bus.in_pc_wdata = '0;
        bus.in_insn = '0; bus.in_intr = 1'b0; bus.in_rd_addr = '0;
        bus.in_rd_wdata = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1, 1'b0);

        // Reset with three entries buffered; in_valid during reset is ignored.
        for (int i = 0; i < 3; i++) retire(32'h10 + 32'(4 * i));
        reset = 1'b0;
        bus.in_valid = 1'b1; bus.in_pc_rdata = 32'h99;
        cycle();
        bus.in_valid = 1'b0;
        reset = 1'b1;
        idle(1, 1'b0);
        check("rst_count", count, 0);
        check("rst_valid", bus.out_valid, 0);

        // Three ordered pushes, then drain.
        retire(32'h100);
        check("first_order_after_reset", bus.out_order, 64'd0);
        retire(32'h104);
        retire(32'h108);
        idle(4, 1'b1);
        check("drained_valid", bus.out_valid, 0);

        // Overflow: 17 pushes into a stalled FIFO, then the 18th gets order 17.
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 17; i++) retire(32'h1000 + 32'(4 * i));
        check("full_count", count, 16);
        check("overflow_set", overflow, 1);
        idle(18, 1'b1);
        retire(32'h2000);
        check("order_after_drop", bus.out_order, 64'd17);
        idle(2, 1'b1);

        // Full FIFO with simultaneous push and pop.
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) retire(32'h3000 + 32'(4 * i));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) retire(32'h4000 + 32'(4 * i));
        check("full_pushpop_count", count, 16);
        check("full_pushpop_ovf", overflow, 0);
        idle(18, 1'b1);

        // Self-loop detection; later loop does not move loop_pc.
        bus.out_ready = 1'b0;
        retire(32'h200);
        retire(32'h200);
        check("loop_flag", loop_detected, 1);
        check("loop_pc_first", loop_pc, 32'h200);
        check("loop_both_stored", count, 2);
        retire(32'h204);
        retire(32'h300);
        retire(32'h300);
        check("loop_pc_kept", loop_pc, 32'h200);

        // Stall: head holds while pushes continue.
        held = sb[0];
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            retire(32'h500 + 32'(4 * i));
            check("hold_head", dut_head(), held);
        end
        idle(12, 1'b1);
        idle(1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
